// File: rtl/nt_holder_verif_pkg.sv
// ---------------------------------------------------------------------------
// nt_holder_verif_pkg
// Shared definitions for the nonce/tag holder and its chunked comparator:
//   - FSM state encoding
//   - helpers that derive beat/chunk counts and counter widths
//   - TAG_MASK builder (ones in bits [0 +: t] of an n-bit word)
// No ports; imported by nt_holder_verif and ct_chunk_cmp.
// ---------------------------------------------------------------------------
package nt_holder_verif_pkg;

   // Upper bound on the register width the mask helper can describe.
   localparam int NT_MAX_W = 1024;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_FULL = 3'd2,
      ST_CMP  = 3'd3,
      ST_DONE = 3'd4
   } nt_state_e;

   function automatic int calc_beats(input int n_bits, input int bus_w);
      return n_bits / bus_w;
   endfunction

   function automatic int calc_chunks(input int n_bits, input int cmp_w);
      return n_bits / cmp_w;
   endfunction

   // Counter width that still works when the count collapses to 1.
   function automatic int cnt_w(input int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

   function automatic logic [NT_MAX_W-1:0] tag_mask(input int t_bits, input int n_bits);
      logic [NT_MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < NT_MAX_W; i++) begin
         if ((i < t_bits) && (i < n_bits)) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/nt_holder_verif_cmp.sv
// ---------------------------------------------------------------------------
// ct_chunk_cmp
// Constant-time chunked comparator: each enabled cycle ORs the masked
// difference of one CMP_W-bit chunk into a sticky diff flag.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   clr_i        clear the diff flag (wins over en_i)
//   en_i         accumulate the chunk selected by chunk_i
//   chunk_i      chunk index
//   nt_i, ref_i  held value and reference snapshot
//   diff_o       1 = some masked bit differed so far
// ---------------------------------------------------------------------------
module ct_chunk_cmp
   import nt_holder_verif_pkg::*;
#(
   parameter int N     = 128,
   parameter int T     = 128,
   parameter int CMP_W = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   clr_i,
   input  logic                                   en_i,
   input  logic [cnt_w(calc_chunks(N, CMP_W))-1:0] chunk_i,
   input  logic [N-1:0]                           nt_i,
   input  logic [N-1:0]                           ref_i,
   output logic                                   diff_o
);

   localparam int                    CHUNKS    = calc_chunks(N, CMP_W);
   localparam logic [NT_MAX_W-1:0]   MASK_FULL = tag_mask(T, N);

   logic [N-1:0]     masked;
   logic [CMP_W-1:0] sel;
   logic             diff_q;
   logic             diff_d;

   always_comb begin
      masked = (nt_i ^ ref_i) & MASK_FULL[N-1:0];
      // Plain mux over all chunks: timing never depends on the data.
      sel = '0;
      for (int c = 0; c < CHUNKS; c++) begin
         if (int'(chunk_i) == c) sel = masked[c*CMP_W +: CMP_W];
      end
      diff_d = diff_q;
      if (clr_i)     diff_d = 1'b0;
      else if (en_i) diff_d = diff_q | (|sel);
   end

   always_ff @(posedge clk) begin
      if (!rst) diff_q <= 1'b0;
      else      diff_q <= diff_d;
   end

   assign diff_o = diff_q;

endmodule

// File: rtl/nt_holder_verif.sv
// ---------------------------------------------------------------------------
// nt_holder_verif
// Multi-beat nonce/tag holder with a constant-time, optionally truncated
// tag comparison against a snapshot of Clyde's output.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   load_start       clear holder and start loading (highest priority)
//   data_in[_valid]  decoder beats; accepted when valid & data_in_ready
//   data_in_ready    high while loading
//   nt_full          holder contains n complete bits
//   nt_out           held nonce/tag
//   ref_in           reference value, captured on cmp_start
//   cmp_start        start comparison (only honoured when full)
//   cmp_busy         comparison running
//   tag_done         one-cycle result strobe
//   tag_valid        sticky result, 1 = bits [0 +: t] matched
// ---------------------------------------------------------------------------
module nt_holder_verif
   import nt_holder_verif_pkg::*;
#(
   parameter int BUS_SIZE = 32,
   parameter int n        = 128,
   parameter int t        = 128,
   parameter int CMP_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_start,
   input  logic [BUS_SIZE-1:0] data_in,
   input  logic                data_in_valid,
   output logic                data_in_ready,
   output logic                nt_full,
   output logic [n-1:0]        nt_out,
   input  logic [n-1:0]        ref_in,
   input  logic                cmp_start,
   output logic                cmp_busy,
   output logic                tag_done,
   output logic                tag_valid
);

   localparam int BEATS  = calc_beats(n, BUS_SIZE);
   localparam int CHUNKS = calc_chunks(n, CMP_W);
   localparam int BW     = cnt_w(BEATS);
   localparam int CW     = cnt_w(CHUNKS);

   localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

   nt_state_e     state_q;
   logic [n-1:0]  nt_q;
   logic [n-1:0]  nt_d;
   logic [n-1:0]  ref_q;
   logic [BW-1:0] beat_q;
   logic [CW-1:0] chunk_q;
   logic          ready_q;
   logic          full_q;
   logic          busy_q;
   logic          done_q;
   logic          valid_q;
   logic          diff;
   logic          cmp_go;
   logic          cmp_clr;

   // New beats enter at the top so the first beat lands in the LSBs.
   if (BEATS > 1) begin : g_shift
      assign nt_d = {data_in, nt_q[n-1:BUS_SIZE]};
   end else begin : g_single
      assign nt_d = data_in;
   end

   assign cmp_go  = (state_q == ST_FULL) && cmp_start && !load_start;
   assign cmp_clr = load_start || cmp_go;

   ct_chunk_cmp #(
      .N     (n),
      .T     (t),
      .CMP_W (CMP_W)
   ) u_cmp (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cmp_clr),
      .en_i    ((state_q == ST_CMP) && !load_start),
      .chunk_i (chunk_q),
      .nt_i    (nt_q),
      .ref_i   (ref_q),
      .diff_o  (diff)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         nt_q    <= '0;
         ref_q   <= '0;
         beat_q  <= '0;
         chunk_q <= '0;
         ready_q <= 1'b0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_start) begin
            state_q <= ST_LOAD;
            nt_q    <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_LOAD: begin
                  if (data_in_valid && ready_q) begin
                     nt_q <= nt_d;
                     if (beat_q == LAST_BEAT) begin
                        state_q <= ST_FULL;
                        ready_q <= 1'b0;
                        full_q  <= 1'b1;
                     end else begin
                        beat_q <= beat_q + 1'b1;
                     end
                  end
               end
               ST_FULL: begin
                  if (cmp_start) begin
                     state_q <= ST_CMP;
                     ref_q   <= ref_in;
                     chunk_q <= '0;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
               ST_CMP: begin
                  // Every chunk is visited; no early exit on a mismatch.
                  if (chunk_q == LAST_CHUNK) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     chunk_q <= chunk_q + 1'b1;
                  end
               end
               ST_DONE: begin
                  // diff now holds all chunks; publish it and allow re-compare.
                  done_q  <= 1'b1;
                  valid_q <= ~diff;
                  state_q <= ST_FULL;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign data_in_ready = ready_q;
   assign nt_full       = full_q;
   assign nt_out        = nt_q;
   assign cmp_busy      = busy_q;
   assign tag_done      = done_q;
   assign tag_valid     = valid_q;

endmodule

// File: tb/tb_nt_holder_verif.sv
// ---------------------------------------------------------------------------
// tb_nt_holder_verif
// Two instances share stimulus: dut_a compares all 128 bits, dut_b only the
// low 64. Expected results are queued when a compare is issued and checked
// when tag_done appears.
// ---------------------------------------------------------------------------
module tb_nt_holder_verif;

   localparam int CHUNKS = 4;
   localparam logic [127:0] MASK_A = {128{1'b1}};
   localparam logic [127:0] MASK_B = {{64{1'b0}}, {64{1'b1}}};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load_start = 1'b0;
   logic [31:0]  data_in = '0;
   logic         data_in_valid = 1'b0;
   logic [127:0] ref_in = '0;
   logic         cmp_start = 1'b0;

   logic         ready_a, full_a, busy_a, done_a, valid_a;
   logic [127:0] nt_a;
   logic         ready_b, full_b, busy_b, done_b, valid_b;
   logic [127:0] nt_b;

   typedef struct {
      int   due;
      logic v;
   } exp_t;

   exp_t         q_a[$];
   exp_t         q_b[$];
   exp_t         e_a;
   exp_t         e_b;
   int           cyc = 0;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic [127:0] nt_model = '0;

   nt_holder_verif #(.BUS_SIZE(32), .n(128), .t(128), .CMP_W(32)) dut_a (
      .clk(clk), .rst(rst), .load_start(load_start), .data_in(data_in),
      .data_in_valid(data_in_valid), .data_in_ready(ready_a), .nt_full(full_a),
      .nt_out(nt_a), .ref_in(ref_in), .cmp_start(cmp_start), .cmp_busy(busy_a),
      .tag_done(done_a), .tag_valid(valid_a)
   );

   nt_holder_verif #(.BUS_SIZE(32), .n(128), .t(64), .CMP_W(32)) dut_b (
      .clk(clk), .rst(rst), .load_start(load_start), .data_in(data_in),
      .data_in_valid(data_in_valid), .data_in_ready(ready_b), .nt_full(full_b),
      .nt_out(nt_b), .ref_in(ref_in), .cmp_start(cmp_start), .cmp_busy(busy_b),
      .tag_done(done_b), .tag_valid(valid_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Scoreboard side: check each tag_done against the oldest queued result.
   always @(negedge clk) begin
      if (rst) begin
         if (done_a) begin
            chk("a_done_expected", q_a.size() > 0, 1);
            if (q_a.size() > 0) begin
               e_a = q_a.pop_front();
               chk("a_done_cycle", cyc, e_a.due);
               chk("a_tag_valid", valid_a, e_a.v);
            end
         end
         if (done_b) begin
            chk("b_done_expected", q_b.size() > 0, 1);
            if (q_b.size() > 0) begin
               e_b = q_b.pop_front();
               chk("b_done_cycle", cyc, e_b.due);
               chk("b_tag_valid", valid_b, e_b.v);
            end
         end
         if (busy_a) chk("a_valid_while_busy", valid_a, 0);
      end
   end

   task automatic load_val(input logic [127:0] val, input int gap);
      load_start = 1'b1;
      tick(1);
      load_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) chk("full_before_last_beat", full_a, 0);
         data_in       = val[i*32 +: 32];
         data_in_valid = 1'b1;
         tick(1);
         data_in_valid = 1'b0;
         tick(gap);
      end
      nt_model = val;
   endtask

   // Issue a compare that the DUT will accept (state FULL).
   task automatic do_cmp(input logic [127:0] r);
      ref_in    = r;
      cmp_start = 1'b1;
      q_a.push_back('{cyc + CHUNKS + 2, ((nt_model ^ r) & MASK_A) == '0});
      q_b.push_back('{cyc + CHUNKS + 2, ((nt_model ^ r) & MASK_B) == '0});
      tick(1);
      cmp_start = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((q_a.size() != 0 || q_b.size() != 0) && k < 30) begin
         tick(1);
         k++;
      end
      chk("drain", q_a.size() + q_b.size(), 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, ready_a, 0);
      chk({tag, "_full"},  full_a,  0);
      chk({tag, "_nt"},    nt_a,    0);
      chk({tag, "_busy"},  busy_a,  0);
      chk({tag, "_done"},  done_a,  0);
      chk({tag, "_valid"}, valid_a, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] v;
      logic [127:0] v2;
      v  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      v2 = 128'h13579BDF_2468ACE0_F0E1D2C3_B4A59687;

      // Power-on reset
      rst = 1'b0;
      tick(2);
      chk_all_zero("por");
      rst = 1'b1;
      tick(1);

      // Reset during the second CMP cycle
      load_val(v, 0);
      do_cmp(v);
      chk("busy_cmp_cycle1", busy_a, 1);
      tick(1);
      rst = 1'b0;
      q_a.delete();
      q_b.delete();
      tick(1);
      chk_all_zero("rst_mid_cmp");
      rst = 1'b1;
      cmp_start = 1'b1;
      tick(1);
      cmp_start = 1'b0;
      chk("idle_cmp_ignored_busy", busy_a, 0);
      tick(8);
      chk("idle_cmp_ignored_done", done_a, 0);
      chk("idle_ready", ready_a, 0);

      // Load with gaps, then an extra beat
      load_val(128'h0F0E0D0C_0B0A0908_07060504_03020100, 2);
      chk("gap_full", full_a, 1);
      chk("gap_nt", nt_a, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      chk("gap_ready_off", ready_a, 0);
      data_in       = 32'hFFFF_FFFF;
      data_in_valid = 1'b1;
      tick(2);
      data_in_valid = 1'b0;
      chk("extra_beat_nt", nt_a, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      chk("extra_beat_full", full_a, 1);

      // Matching compare: busy for exactly CHUNKS cycles, sticky result
      load_val(v, 0);
      chk("match_nt", nt_a, v);
      do_cmp(v);
      for (int i = 0; i < CHUNKS; i++) begin
         chk("match_busy", busy_a, 1);
         tick(1);
      end
      chk("match_busy_end", busy_a, 0);
      drain();
      chk("match_valid", valid_a, 1);
      tick(3);
      chk("match_sticky", valid_a, 1);
      chk("match_nt_kept", nt_a, v);

      // Mismatch in the first and last chunk
      do_cmp(v ^ 128'd1);
      drain();
      chk("mis_bit0", valid_a, 0);
      do_cmp(v ^ (128'd1 << 127));
      drain();
      chk("mis_bit127", valid_a, 0);

      // Truncated compare (dut_b, t=64)
      do_cmp(v ^ (128'd1 << 100));
      drain();
      chk("trunc_bit100_b", valid_b, 1);
      chk("trunc_bit100_a", valid_a, 0);
      do_cmp(v ^ (128'd1 << 63));
      drain();
      chk("trunc_bit63_b", valid_b, 0);

      // load_start beats cmp_start in FULL
      do_cmp(v);
      drain();
      chk("prio_pre_valid", valid_a, 1);
      load_start = 1'b1;
      cmp_start  = 1'b1;
      ref_in     = v;
      tick(1);
      load_start = 1'b0;
      cmp_start  = 1'b0;
      chk("prio_ready", ready_a, 1);
      chk("prio_full", full_a, 0);
      chk("prio_valid", valid_a, 0);
      chk("prio_busy", busy_a, 0);
      tick(8);
      chk("prio_no_done", done_a, 0);

      // ref_in disturbed during CMP: snapshot decides
      load_val(v2, 1);
      do_cmp(v2);
      ref_in = ~v2;
      drain();
      chk("snapshot_valid", valid_a, 1);
      chk("snapshot_valid_b", valid_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
